// File: rtl/wb_sharedbus_pkg.sv
// Shared types and sizing constants for the wb_sharedbus interconnect.
package wb_sharedbus_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_SLAVES  = 16;
    localparam int MIDX_W      = 3;
    localparam int SIDX_W      = 4;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus arbiter: registered grant, held for a master's whole cyc,
// and one idle cycle after every release.
module wb_rr_arbiter
    import wb_sharedbus_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_MASTERS-1:0] i_cyc,
    output logic                   o_gnt_valid,
    output logic [MIDX_W-1:0]      o_gnt_idx
);

    arb_state_t              r_state;
    logic                    r_gnt_valid;
    logic [MIDX_W-1:0]       r_gnt_idx;
    logic [MIDX_W-1:0]       r_last;
    logic [MAX_MASTERS-1:0]  w_cyc_ext;
    logic [MIDX_W-1:0]       w_cand;
    logic [MIDX_W-1:0]       w_pick;
    logic                    w_found;

    assign w_cyc_ext = MAX_MASTERS'(i_cyc);

    // Search starts just after the last granted master and wraps around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_cand  = r_last;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            w_cand = MIDX_W'((int'(r_last) + off) % NUM_MASTERS);
            if (!w_found && w_cyc_ext[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Arbitration state machine with registered grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ARB_IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
            r_last      <= MIDX_W'(NUM_MASTERS - 1);
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_state     <= ARB_BUSY;
                        r_gnt_valid <= 1'b1;
                        r_gnt_idx   <= w_pick;
                        r_last      <= w_pick;
                    end
                end
                ARB_BUSY: begin
                    if (!w_cyc_ext[r_gnt_idx]) begin
                        r_state     <= ARB_IDLE;
                        r_gnt_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ARB_IDLE;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt_valid = r_gnt_valid;
    assign o_gnt_idx   = r_gnt_idx;

endmodule

// File: rtl/wb_sharedbus.sv
// Shared-bus Wishbone interconnect: N masters, M slaves, address decode and
// decode-miss error. Optional stall watchdog under WB_SHAREDBUS_TIMEOUT_EN.
module wb_sharedbus
    import wb_sharedbus_pkg::*;
#(
    parameter int                           NUM_MASTERS = 4,
    parameter int                           NUM_SLAVES  = 8,
    parameter int                           ADR_W       = 32,
    parameter int                           DAT_W       = 32,
    parameter logic [NUM_SLAVES*ADR_W-1:0]  SLAVE_BASE  = '0,
    parameter logic [NUM_SLAVES*ADR_W-1:0]  SLAVE_MASK  = '0,
    parameter int                           TIMEOUT     = 255
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_MASTERS*ADR_W-1:0]       m_adr_i,
    input  logic [NUM_MASTERS*DAT_W-1:0]       m_dat_i,
    input  logic [NUM_MASTERS*(DAT_W/8)-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0]             m_we_i,
    input  logic [NUM_MASTERS-1:0]             m_cyc_i,
    input  logic [NUM_MASTERS-1:0]             m_stb_i,
    output logic [NUM_MASTERS*DAT_W-1:0]       m_dat_o,
    output logic [NUM_MASTERS-1:0]             m_ack_o,
    output logic [NUM_MASTERS-1:0]             m_err_o,
    output logic [NUM_MASTERS-1:0]             m_rty_o,
    output logic [NUM_SLAVES*ADR_W-1:0]        s_adr_o,
    output logic [NUM_SLAVES*DAT_W-1:0]        s_dat_o,
    output logic [NUM_SLAVES*(DAT_W/8)-1:0]    s_sel_o,
    output logic [NUM_SLAVES-1:0]              s_we_o,
    output logic [NUM_SLAVES-1:0]              s_cyc_o,
    output logic [NUM_SLAVES-1:0]              s_stb_o,
    input  logic [NUM_SLAVES*DAT_W-1:0]        s_dat_i,
    input  logic [NUM_SLAVES-1:0]              s_ack_i,
    input  logic [NUM_SLAVES-1:0]              s_err_i,
    input  logic [NUM_SLAVES-1:0]              s_rty_i,
    output logic                               bus_err,
    output logic [2:0]                         err_master
);

    localparam int SEL_W = DAT_W / 8;

    logic                    w_gnt_valid;
    logic [MIDX_W-1:0]       w_gnt_idx;
    logic [NUM_MASTERS-1:0]  w_gnt_oh;
    logic [ADR_W-1:0]        w_adr;
    logic [DAT_W-1:0]        w_wdat;
    logic [SEL_W-1:0]        w_sel;
    logic                    w_we, w_cyc, w_stb;
    logic [NUM_SLAVES-1:0]   w_slv_oh;
    logic                    w_hit;
    logic [DAT_W-1:0]        w_rdat;
    logic                    w_ack, w_err, w_rty;
    logic                    w_miss, w_stb_pend, w_to_hit;
    logic                    r_int_err;
    logic [MIDX_W-1:0]       r_err_master;

    wb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_cyc       (m_cyc_i),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // AND-OR mux of the granted master's request onto the shared bus.
    always_comb begin
        w_gnt_oh = '0;
        w_adr    = '0;
        w_wdat   = '0;
        w_sel    = '0;
        w_we     = 1'b0;
        w_cyc    = 1'b0;
        w_stb    = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_gnt_oh[m] = w_gnt_valid && (w_gnt_idx == MIDX_W'(m));
            w_adr  = w_adr  | (m_adr_i[m*ADR_W +: ADR_W] & {ADR_W{w_gnt_oh[m]}});
            w_wdat = w_wdat | (m_dat_i[m*DAT_W +: DAT_W] & {DAT_W{w_gnt_oh[m]}});
            w_sel  = w_sel  | (m_sel_i[m*SEL_W +: SEL_W] & {SEL_W{w_gnt_oh[m]}});
            w_we   = w_we   | (m_we_i[m]  & w_gnt_oh[m]);
            w_cyc  = w_cyc  | (m_cyc_i[m] & w_gnt_oh[m]);
            w_stb  = w_stb  | (m_cyc_i[m] & m_stb_i[m] & w_gnt_oh[m]);
        end
    end

    // Address decode: the lowest matching slave index wins.
    always_comb begin
        w_slv_oh = '0;
        w_hit    = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_slv_oh[k] = !w_hit &&
                ((w_adr & SLAVE_MASK[k*ADR_W +: ADR_W]) == SLAVE_BASE[k*ADR_W +: ADR_W]);
            w_hit = w_hit | w_slv_oh[k];
        end
    end

    assign s_adr_o = {NUM_SLAVES{w_adr}};
    assign s_dat_o = {NUM_SLAVES{w_wdat}};
    assign s_sel_o = {NUM_SLAVES{w_sel}};
    assign s_we_o  = {NUM_SLAVES{w_we}};
    assign s_cyc_o = w_slv_oh & {NUM_SLAVES{w_cyc}};
    assign s_stb_o = w_slv_oh & {NUM_SLAVES{w_stb}};

    // Selected slave's response, valid only while a granted cycle is active.
    always_comb begin
        w_rdat = '0;
        w_ack  = 1'b0;
        w_err  = 1'b0;
        w_rty  = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_rdat = w_rdat | (s_dat_i[k*DAT_W +: DAT_W] & {DAT_W{w_slv_oh[k] & w_cyc}});
            w_ack  = w_ack  | (s_ack_i[k] & w_slv_oh[k] & w_cyc);
            w_err  = w_err  | (s_err_i[k] & w_slv_oh[k] & w_cyc);
            w_rty  = w_rty  | (s_rty_i[k] & w_slv_oh[k] & w_cyc);
        end
    end

    // Route the response (plus interconnect errors) to the granted master only.
    always_comb begin
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            m_dat_o[m*DAT_W +: DAT_W] = w_rdat & {DAT_W{w_gnt_oh[m]}};
            m_ack_o[m] = w_ack & w_gnt_oh[m];
            m_err_o[m] = (w_err | r_int_err) & w_gnt_oh[m];
            m_rty_o[m] = w_rty & w_gnt_oh[m];
        end
    end

    assign w_miss     = w_stb & !w_hit;
    assign w_stb_pend = w_stb & w_hit & !(w_ack | w_err | w_rty);

`ifdef WB_SHAREDBUS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    assign w_to_hit = w_stb_pend && !r_int_err && (r_to_cnt == TO_W'(TIMEOUT - 1));

    // Counts unanswered strobe cycles; any response or abort restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (!w_stb_pend || r_int_err || w_to_hit) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_to_hit         = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0) | w_stb_pend;
`endif

    // Interconnect-generated error pulse and the master it was charged to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_int_err    <= 1'b0;
            r_err_master <= '0;
        end else if (!r_int_err && (w_miss || w_to_hit)) begin
            r_int_err    <= 1'b1;
            r_err_master <= w_gnt_idx;
        end else begin
            r_int_err    <= 1'b0;
        end
    end

    assign bus_err    = r_int_err;
    assign err_master = r_err_master;

endmodule

// File: tb/tb_wb_sharedbus.sv
// Directed self-checking bench for wb_sharedbus (4 masters, 2 slaves).
module tb_wb_sharedbus;

    localparam int NM = 4;
    localparam int NS = 2;

    logic             clk;
    logic             reset_n;
    logic [NM*32-1:0] m_adr_i, m_dat_i, m_dat_o;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o, m_rty_o;
    logic [NS*32-1:0] s_adr_o, s_dat_o, s_dat_i;
    logic [NS*4-1:0]  s_sel_o;
    logic [NS-1:0]    s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
    logic             bus_err;
    logic [2:0]       err_master;

    int n_vec = 0;
    int n_err = 0;

    wb_sharedbus #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .ADR_W       (32),
        .DAT_W       (32),
        .SLAVE_BASE  ({32'h5000_0000, 32'h4000_0000}),
        .SLAVE_MASK  ({32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT     (16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .bus_err(bus_err), .err_master(err_master)
    );

    // Slave 0 answers every strobe at once; slave 1 never answers.
    assign s_ack_i = {1'b0, s_cyc_o[0] & s_stb_o[0]};
    assign s_err_i = 2'b00;
    assign s_rty_i = 2'b00;
    assign s_dat_i = {32'h0000_0000, 32'hDEAD_BEEF};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int idx, input logic req, input logic [31:0] adr);
        m_cyc_i[idx]            = req;
        m_stb_i[idx]            = req;
        m_adr_i[idx*32 +: 32]   = adr;
    endtask

    logic [31:0] adr_tab [3] = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008};
    int          exp_gnt [6] = '{0, 1, 2, 0, 1, 2};
    logic [3:0]  exp_ack;
    logic        seen;

    initial begin
        reset_n = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '1; m_we_i = '0;
        m_cyc_i = '0; m_stb_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_cyc", s_cyc_o, 2'b00);
        chk("rst_s_stb", s_stb_o, 2'b00);
        chk("rst_m_ack", m_ack_o, 4'b0000);
        chk("rst_m_err", m_err_o, 4'b0000);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_err_master", err_master, 3'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single read by master 0 from slave 0
        set_m(0, 1'b1, 32'h4000_0010);
        #1 chk("rd_stb_before_grant", s_stb_o, 2'b00);
        @(negedge clk);
        chk("rd_s_stb", s_stb_o, 2'b01);
        chk("rd_m_ack", m_ack_o, 4'b0001);
        chk("rd_m0_dat", m_dat_o[31:0], 32'hDEAD_BEEF);
        chk("rd_m1_dat", m_dat_o[63:32], 32'h0000_0000);
        chk("rd_adr_bcast", s_adr_o[63:32], 32'h4000_0010);
        set_m(0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rd_release", s_cyc_o, 2'b00);

        // Decode miss from master 1
        set_m(1, 1'b1, 32'h9000_0000);
        @(negedge clk);
        chk("miss_no_stb", s_stb_o, 2'b00);
        chk("miss_err_early", m_err_o, 4'b0000);
        chk("miss_bus_err_early", bus_err, 1'b0);
        @(negedge clk);
        chk("miss_m_err", m_err_o, 4'b0010);
        chk("miss_bus_err", bus_err, 1'b1);
        chk("miss_err_master", err_master, 3'd1);
        chk("miss_no_stb2", s_stb_o, 2'b00);
        set_m(1, 1'b0, 32'h0);
        @(negedge clk);
        chk("miss_err_one_cycle", m_err_o, 4'b0000);
        chk("miss_bus_err_one_cycle", bus_err, 1'b0);

        // Master 2 holds a 4-beat burst while master 0 waits
        set_m(2, 1'b1, 32'h4000_0020);
        set_m(0, 1'b1, 32'h4000_0000);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("burst_m2_ack", m_ack_o, 4'b0100);
        end
        set_m(2, 1'b0, 32'h0);
        @(negedge clk);
        chk("burst_idle_ack", m_ack_o, 4'b0000);
        chk("burst_idle_cyc", s_cyc_o, 2'b00);
        @(negedge clk);
        chk("burst_m0_after", m_ack_o, 4'b0001);

        // Reset in the middle of master 0's transfer
        set_m(1, 1'b1, adr_tab[1]);
        set_m(2, 1'b1, adr_tab[2]);
        @(negedge clk);
        chk("rstmid_pre_cyc", s_cyc_o, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_s_cyc", s_cyc_o, 2'b00);
        chk("rstmid_m_ack", m_ack_o, 4'b0000);
        chk("rstmid_err_master", err_master, 3'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Round robin among masters 0,1,2 with an idle cycle between grants
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_ack = (i % 2 == 0) ? (4'b0001 << exp_gnt[i/2]) : 4'b0000;
            chk("rr_ack", m_ack_o, exp_ack);
            for (int m = 0; m < 3; m++) set_m(m, !m_ack_o[m], adr_tab[m]);
        end
        for (int m = 0; m < 3; m++) set_m(m, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        // Master 3 strobes slave 1, which never answers
        set_m(3, 1'b1, 32'h5000_0000);
        @(negedge clk);
        chk("to_s_stb", s_stb_o, 2'b10);
`ifdef WB_SHAREDBUS_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("to_m_err", m_err_o, (k == 16) ? 4'b1000 : 4'b0000);
        end
        chk("to_bus_err", bus_err, 1'b1);
        chk("to_err_master", err_master, 3'd3);
`else
        seen = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if ((m_err_o != 4'b0000) || bus_err) seen = 1'b1;
            else seen = seen;
        end
        chk("to_no_err", seen, 1'b0);
        chk("to_stall_stb", s_stb_o, 2'b10);
`endif
        set_m(3, 1'b0, 32'h0);
        @(negedge clk);
        chk("end_idle_cyc", s_cyc_o, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_sharedbus.md
WB_SHAREDBUS -- requirements
Module: wb_sharedbus

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of Wishbone masters (1..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 8, number of Wishbone slaves (1..16).
REQ-003 SHALL have parameter ADR_W, default 32, address width.
REQ-004 SHALL have parameter DAT_W, default 32, data width; SEL width = DAT_W/8.
REQ-005 SHALL have parameter SLAVE_BASE, default all-zero, NUM_SLAVES*ADR_W packed base addresses.
REQ-006 SHALL have parameter SLAVE_MASK, default all-zero, NUM_SLAVES*ADR_W packed decode masks.
REQ-007 SHALL have parameter TIMEOUT, default 255, cycles before an unanswered strobe is aborted.
REQ-008 clk  in  1  system clock.
REQ-009 reset_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-010 m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i  in  NUM_MASTERS x field  packed master requests.
REQ-011 m_dat_o/m_ack_o/m_err_o/m_rty_o  out  NUM_MASTERS x field  packed master responses.
REQ-012 s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o  out  NUM_SLAVES x field  packed slave requests.
REQ-013 s_dat_i/s_ack_i/s_err_i/s_rty_i  in  NUM_SLAVES x field  packed slave responses.
REQ-014 bus_err  out  1  one-cycle pulse on decode miss or timeout.
REQ-015 err_master  out  3  index of master owning the last errored cycle.

Function
REQ-016 Arbiter SHALL use states IDLE and BUSY; IDLE->BUSY when any m_cyc_i high, BUSY->IDLE when granted master's m_cyc_i low.
REQ-017 In IDLE, grant SHALL go to the first requesting master after the last granted index (round robin, wrap NUM_MASTERS-1 -> 0); after reset, search starts at master 0.
REQ-018 Grant SHALL be registered: cyc asserted at edge N yields slave s_cyc_o/s_stb_o in cycle N+1.
REQ-019 Grant SHALL be held for the entire m_cyc_i assertion, including multi-beat/locked transfers; other masters' requests are ignored.
REQ-020 Decode SHALL select slave k when (adr & SLAVE_MASK[k]) == SLAVE_BASE[k]; lowest matching k wins.
REQ-021 Only the selected slave SHALL see s_cyc_o/s_stb_o; adr/dat/sel/we SHALL be broadcast to all slaves.
REQ-022 Selected slave's ack/err/rty/dat SHALL route combinationally to the granted master only; all other masters see zero.
REQ-023 Decode miss with stb high SHALL assert m_err_o to the granted master for exactly one cycle, one cycle after stb, with no slave strobed.
REQ-024 Grant release SHALL insert one IDLE cycle before the next grant; simultaneous release and new request is served on the following cycle.
REQ-025 bus_err SHALL pulse concurrently with any interconnect-generated m_err_o; err_master SHALL update in that cycle.

Reset
REQ-026 reset_n low SHALL force IDLE, no grant, last-grant pointer to NUM_MASTERS-1, timeout counter 0, all s_cyc_o/s_stb_o/m_ack_o/m_err_o/m_rty_o/bus_err 0, err_master 0.
REQ-027 Reset asserted mid-transfer SHALL drop s_cyc_o/s_stb_o asynchronously; no response is delivered.

Configuration
REQ-028 With WB_SHAREDBUS_TIMEOUT_EN defined, a counter SHALL count cycles of granted stb without ack/err/rty; reaching TIMEOUT SHALL pulse m_err_o and bus_err for one cycle and clear the counter; any slave response clears it.
REQ-029 Without WB_SHAREDBUS_TIMEOUT_EN, no counter exists, TIMEOUT is ignored, and an unanswered strobe stalls indefinitely.

Structure
REQ-030 Package wb_sharedbus_pkg SHALL hold arbiter state encoding and max-count constants (8 masters, 16 slaves).
REQ-031 Sub-module wb_rr_arbiter SHALL implement REQ-016/017/019/024; decode, muxing and timeout stay in the top.

Verification
REQ-032 Master 0 reads adr 0x4000_0010, slave 0 base 0x4000_0000 mask 0xF000_0000 acks 0xDEADBEEF -> s_stb_o[0] one cycle after request, m_dat_o[0]=0xDEADBEEF with m_ack_o[0].
REQ-033 Masters 0,1,2 request continuously, single-beat cycles -> grants sequence 0,1,2,0,1,2 with one idle cycle between.
REQ-034 Master 1 accesses 0x9000_0000 (no match) -> m_err_o[1] one cycle, bus_err pulse, err_master=1, no s_stb_o.
REQ-035 TIMEOUT=16, enabled, slave never responds -> m_err_o pulse exactly 16 cycles after stb, bus_err=1; disabled -> no err after 1000 cycles.
REQ-036 Master 2 holds cyc for 4-beat burst while master 0 requests -> master 0 granted only after master 2 drops cyc plus one idle cycle.
REQ-037 reset_n low mid-burst -> s_cyc_o all zero immediately; after release, first requester 0 granted first.
